// File: rtl/writeback_unit_if.sv
// writeback_unit_if: execute-side, data-memory and register-file signals of the writeback stage.
interface writeback_unit_if;
  logic        ex_valid_i;
  logic        ex_ready_o;
  logic [4:0]  ex_itype_i;
  logic [4:0]  ex_rd_i;
  logic [2:0]  ex_funct3_i;
  logic [31:0] ex_result_i;
  logic [31:0] ex_link_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic [31:0] wd_o;
  logic        wd_q_o;
  logic [4:0]  wd_rd_o;
  logic [31:0] retired_o;
  logic        mem_err_o;
  modport slave (
    input  ex_valid_i, ex_itype_i, ex_rd_i, ex_funct3_i, ex_result_i, ex_link_i, mem_ack_i, mem_rdata_i,
    output ex_ready_o, mem_req_o, mem_addr_o, wd_o, wd_q_o, wd_rd_o, retired_o, mem_err_o
  );
  modport master (
    output ex_valid_i, ex_itype_i, ex_rd_i, ex_funct3_i, ex_result_i, ex_link_i, mem_ack_i, mem_rdata_i,
    input  ex_ready_o, mem_req_o, mem_addr_o, wd_o, wd_q_o, wd_rd_o, retired_o, mem_err_o
  );
endinterface

// File: rtl/writeback_unit.sv
// writeback_unit: final pipeline stage; register write-back, load handshake with timeout, retire count.
module writeback_unit #(
  parameter int          TIMEOUT     = 16,
  parameter logic [31:0] RESET_COUNT = 32'd0
) (
  input logic             clk,
  input logic             reset,
  writeback_unit_if.slave bus
);
  localparam logic [4:0] RTYPE = 5'd1, ITYPE = 5'd2, STYPE = 5'd3, BTYPE = 5'd4,
                         LTYPE = 5'd5, UTYPE = 5'd6, JTYPE = 5'd7, JRTYPE = 5'd8;
  typedef enum logic [1:0] {IDLE, LOAD, WRITE} state_t;
  state_t      state_q, state_d;
  logic [4:0]  rd_q, rd_d, wd_rd_q, wd_rd_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d, wd_q, wd_d, retired_q, retired_d;
  logic        strobe_q, strobe_d, err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        is_link, writes_reg;
  function automatic logic [31:0] ext(input logic [31:0] w, input logic [2:0] f3, input logic [1:0] a);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    return f3 == 3'b000 ? {{24{b[7]}}, b} :
           f3 == 3'b001 ? {{16{h[15]}}, h} :
           f3 == 3'b100 ? {24'b0, b} :
           f3 == 3'b101 ? {16'b0, h} : w;
  endfunction
  assign is_link    = bus.ex_itype_i == JTYPE || bus.ex_itype_i == JRTYPE;
  assign writes_reg = is_link || bus.ex_itype_i == RTYPE || bus.ex_itype_i == ITYPE || bus.ex_itype_i == UTYPE;
  always_comb begin
    state_d   = state_q;
    rd_d      = rd_q;
    funct3_d  = funct3_q;
    addr_d    = addr_q;
    wd_d      = wd_q;
    wd_rd_d   = wd_rd_q;
    strobe_d  = 1'b0;
    retired_d = retired_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    if (state_q == IDLE && bus.ex_valid_i) begin
      rd_d     = bus.ex_rd_i;
      funct3_d = bus.ex_funct3_i;
      addr_d   = bus.ex_result_i;
      cnt_d    = 8'd0;
      state_d  = bus.ex_itype_i == LTYPE ? LOAD : WRITE;
      if (bus.ex_itype_i != LTYPE) begin
        wd_d      = is_link ? bus.ex_link_i : bus.ex_result_i;
        wd_rd_d   = bus.ex_rd_i;
        strobe_d  = writes_reg && bus.ex_rd_i != 5'd0;
        retired_d = retired_q + 32'd1;
      end
    end else if (state_q == LOAD) begin
      cnt_d = cnt_q + 8'd1;
      if (bus.mem_ack_i) begin
        state_d   = WRITE;
        wd_d      = ext(bus.mem_rdata_i, funct3_q, addr_q[1:0]);
        wd_rd_d   = rd_q;
        strobe_d  = rd_q != 5'd0;
        retired_d = retired_q + 32'd1;
      end else if (cnt_d == 8'(TIMEOUT)) begin
        state_d = IDLE;
        err_d   = 1'b1;
      end
    end else if (state_q == WRITE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      rd_q      <= '0;
      funct3_q  <= '0;
      addr_q    <= '0;
      wd_q      <= '0;
      wd_rd_q   <= '0;
      strobe_q  <= 1'b0;
      retired_q <= RESET_COUNT;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      rd_q      <= rd_d;
      funct3_q  <= funct3_d;
      addr_q    <= addr_d;
      wd_q      <= wd_d;
      wd_rd_q   <= wd_rd_d;
      strobe_q  <= strobe_d;
      retired_q <= retired_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end
  assign bus.ex_ready_o = state_q == IDLE;
  assign bus.mem_req_o  = state_q == LOAD;
  assign bus.mem_addr_o = {addr_q[31:2], 2'b00};
  assign bus.wd_o       = wd_q;
  assign bus.wd_q_o     = strobe_q;
  assign bus.wd_rd_o    = wd_rd_q;
  assign bus.retired_o  = retired_q;
  assign bus.mem_err_o  = err_q;
endmodule

// File: tb/tb_writeback_unit.sv
// tb_writeback_unit: scoreboard-driven scenarios for writeback_unit.
module tb_writeback_unit;
  localparam logic [4:0] RTYPE = 5'd1, ITYPE = 5'd2, STYPE = 5'd3, BTYPE = 5'd4,
                         LTYPE = 5'd5, UTYPE = 5'd6, JTYPE = 5'd7, JRTYPE = 5'd8;
  typedef struct packed {logic [4:0] rd; logic [31:0] d;} exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  exp_t exp_q[$];
  exp_t e;
  bit got;
  writeback_unit_if bus();
  writeback_unit #(.TIMEOUT(16), .RESET_COUNT(32'd0)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic send(input logic [4:0] it, input logic [4:0] rd, input logic [2:0] f3,
                      input logic [31:0] res, input logic [31:0] link);
    for (int i = 0; i < 40 && !bus.ex_ready_o; i++) @(negedge clk);
    total++;
    if (!bus.ex_ready_o) begin bad++; $display("FAIL ready_wait ready=0 required=1"); end
    bus.ex_valid_i = 1'b1; bus.ex_itype_i = it; bus.ex_rd_i = rd;
    bus.ex_funct3_i = f3; bus.ex_result_i = res; bus.ex_link_i = link;
    @(negedge clk);
    bus.ex_valid_i = 1'b0;
  endtask

  task automatic wait_strobe(input int budget, output bit g);
    g = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (bus.wd_q_o) begin g = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({bus.ex_ready_o, bus.mem_req_o, bus.wd_q_o, bus.mem_err_o} !== 4'b1000) begin
      bad++; $display("FAIL reset_flags rdy/req/wq/err=%b required=1000",
                      {bus.ex_ready_o, bus.mem_req_o, bus.wd_q_o, bus.mem_err_o});
    end
    total++;
    if (bus.mem_addr_o !== 32'd0 || bus.wd_o !== 32'd0 || bus.wd_rd_o !== 5'd0) begin
      bad++; $display("FAIL reset_data addr=%h wd=%h rd=%0d required 0", bus.mem_addr_o, bus.wd_o, bus.wd_rd_o);
    end
    total++;
    if (bus.retired_o !== 32'd0) begin bad++; $display("FAIL reset_retired got=%0d required=0", bus.retired_o); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_rtype;
    exp_q.push_back('{rd: 5'd5, d: 32'h0000_1234});
    send(RTYPE, 5'd5, 3'd0, 32'h0000_1234, 32'h0);
    total++;
    if (bus.ex_ready_o !== 1'b0) begin bad++; $display("FAIL rtype_busy ready=%b required=0", bus.ex_ready_o); end
    wait_strobe(4, got);
    e = exp_q.pop_front();
    total++;
    if (!got || bus.wd_rd_o !== e.rd || bus.wd_o !== e.d) begin
      bad++; $display("FAIL rtype_write strobe=%0b rd=%0d wd=%h required rd=%0d wd=%h", got, bus.wd_rd_o, bus.wd_o, e.rd, e.d);
    end
    total++;
    if (bus.retired_o !== 32'd1) begin bad++; $display("FAIL rtype_retired got=%0d required=1", bus.retired_o); end
    @(negedge clk);
    total++;
    if (bus.ex_ready_o !== 1'b1 || bus.wd_q_o !== 1'b0 || bus.wd_o !== 32'h1234) begin
      bad++; $display("FAIL rtype_after ready=%b wq=%b wd=%h required 1,0,00001234", bus.ex_ready_o, bus.wd_q_o, bus.wd_o);
    end
  endtask

  task automatic do_load(input string nm, input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd,
                         input logic [31:0] rdata, input int delay, input logic [31:0] expv);
    int held;
    held = 0;
    exp_q.push_back('{rd: rd, d: expv});
    send(LTYPE, rd, f3, addr, 32'h0);
    for (int i = 0; i < delay; i++) begin
      if (bus.mem_req_o === 1'b1 && bus.mem_addr_o === {addr[31:2], 2'b00} && bus.wd_q_o === 1'b0) held++;
      if (i == delay - 1) begin bus.mem_ack_i = 1'b1; bus.mem_rdata_i = rdata; end
      @(negedge clk);
    end
    bus.mem_ack_i = 1'b0; bus.mem_rdata_i = 32'hDEAD_BEEF;
    total++;
    if (held != delay) begin bad++; $display("FAIL %s_req_hold cycles=%0d required=%0d", nm, held, delay); end
    wait_strobe(4, got);
    e = exp_q.pop_front();
    total++;
    if (!got || bus.wd_rd_o !== e.rd || bus.wd_o !== e.d) begin
      bad++; $display("FAIL %s strobe=%0b rd=%0d wd=%h required rd=%0d wd=%h", nm, got, bus.wd_rd_o, bus.wd_o, e.rd, e.d);
    end
    @(negedge clk);
  endtask

  task automatic test_loads;
    logic [31:0] r0;
    r0 = bus.retired_o;
    do_load("lb",  3'b000, 32'h0000_1003, 5'd7, 32'h80FF_0000, 3, 32'hFFFF_FF80);
    do_load("lbu", 3'b100, 32'h0000_1003, 5'd7, 32'h80FF_0000, 3, 32'h0000_0080);
    do_load("lh",  3'b001, 32'h0000_0002, 5'd8, 32'h8001_7FFF, 1, 32'hFFFF_8001);
    do_load("lhu", 3'b101, 32'h0000_0000, 5'd9, 32'h8001_7FFF, 2, 32'h0000_7FFF);
    do_load("lw",  3'b010, 32'h0000_2001, 5'd3, 32'hCAFE_F00D, 5, 32'hCAFE_F00D);
    do_load("lb1", 3'b000, 32'h0000_2001, 5'd4, 32'h1234_7F56, 1, 32'h0000_007F);
    total++;
    if (bus.retired_o !== r0 + 32'd6) begin bad++; $display("FAIL load_retired got=%0d required=%0d", bus.retired_o, r0 + 32'd6); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] r0;
    int strobes;
    exp_q.push_back('{rd: 5'd1, d: 32'h0000_0104});
    send(JTYPE, 5'd1, 3'd0, 32'h0000_0FFF, 32'h0000_0104);
    wait_strobe(4, got);
    e = exp_q.pop_front();
    total++;
    if (!got || bus.wd_rd_o !== e.rd || bus.wd_o !== e.d) begin
      bad++; $display("FAIL jal_link strobe=%0b rd=%0d wd=%h required rd=%0d wd=%h", got, bus.wd_rd_o, bus.wd_o, e.rd, e.d);
    end
    @(negedge clk);
    r0 = bus.retired_o;
    strobes = 0;
    send(STYPE, 5'd2, 3'd0, 32'h1, 32'h0);
    if (bus.wd_q_o) strobes++;
    @(negedge clk);
    send(BTYPE, 5'd3, 3'd0, 32'h2, 32'h0);
    if (bus.wd_q_o) strobes++;
    @(negedge clk);
    send(ITYPE, 5'd0, 3'd0, 32'h3, 32'h0);
    if (bus.wd_q_o) strobes++;
    total++;
    if (bus.wd_rd_o !== 5'd0 || bus.wd_o !== 32'h3) begin
      bad++; $display("FAIL rd0_data rd=%0d wd=%h required rd=0 wd=00000003", bus.wd_rd_o, bus.wd_o);
    end
    @(negedge clk);
    total++;
    if (strobes != 0) begin bad++; $display("FAIL nowrite_strobes got=%0d required=0", strobes); end
    total++;
    if (bus.retired_o !== r0 + 32'd3) begin bad++; $display("FAIL nowrite_retired got=%0d required=%0d", bus.retired_o, r0 + 32'd3); end
  endtask

  task automatic test_timeout;
    logic [31:0] r0;
    int req_cycles, strobes;
    r0 = bus.retired_o;
    req_cycles = 0; strobes = 0;
    send(LTYPE, 5'd6, 3'b010, 32'h0000_3000, 32'h0);
    for (int i = 0; i < 22; i++) begin
      if (bus.mem_req_o) req_cycles++;
      if (bus.wd_q_o) strobes++;
      @(negedge clk);
    end
    total++;
    if (req_cycles != 16) begin bad++; $display("FAIL timeout_req cycles=%0d required=16", req_cycles); end
    total++;
    if (bus.mem_err_o !== 1'b1 || strobes != 0 || bus.ex_ready_o !== 1'b1) begin
      bad++; $display("FAIL timeout_state err=%b strobes=%0d ready=%b required 1,0,1", bus.mem_err_o, strobes, bus.ex_ready_o);
    end
    total++;
    if (bus.retired_o !== r0) begin bad++; $display("FAIL timeout_retired got=%0d required=%0d", bus.retired_o, r0); end
    exp_q.push_back('{rd: 5'd10, d: 32'hA5A5_0001});
    send(UTYPE, 5'd10, 3'd0, 32'hA5A5_0001, 32'h0);
    wait_strobe(4, got);
    e = exp_q.pop_front();
    total++;
    if (!got || bus.wd_rd_o !== e.rd || bus.wd_o !== e.d || bus.mem_err_o !== 1'b1) begin
      bad++; $display("FAIL after_timeout strobe=%0b rd=%0d wd=%h err=%b required rd=%0d wd=%h err=1",
                      got, bus.wd_rd_o, bus.wd_o, bus.mem_err_o, e.rd, e.d);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_load;
    int strobes;
    strobes = 0;
    send(LTYPE, 5'd11, 3'b010, 32'h0000_4000, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (bus.mem_req_o !== 1'b0 || bus.ex_ready_o !== 1'b1 || bus.retired_o !== 32'd0 || bus.mem_err_o !== 1'b0) begin
      bad++; $display("FAIL midload_reset req=%b ready=%b retired=%0d err=%b required 0,1,0,0",
                      bus.mem_req_o, bus.ex_ready_o, bus.retired_o, bus.mem_err_o);
    end
    reset = 1'b0;
    bus.mem_ack_i = 1'b1; bus.mem_rdata_i = 32'h1111_2222;
    repeat (2) begin @(negedge clk); if (bus.wd_q_o) strobes++; end
    bus.mem_ack_i = 1'b0;
    repeat (2) begin @(negedge clk); if (bus.wd_q_o) strobes++; end
    total++;
    if (strobes != 0 || bus.retired_o !== 32'd0) begin
      bad++; $display("FAIL stray_ack strobes=%0d retired=%0d required 0,0", strobes, bus.retired_o);
    end
  endtask

  initial begin
    bus.ex_valid_i = 1'b0; bus.ex_itype_i = '0; bus.ex_rd_i = '0; bus.ex_funct3_i = '0;
    bus.ex_result_i = '0; bus.ex_link_i = '0; bus.mem_ack_i = 1'b0; bus.mem_rdata_i = '0;
    @(negedge clk);
    test_reset;
    test_rtype;
    test_loads;
    test_back_to_back;
    test_timeout;
    test_reset_mid_load;
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_left pending=%0d required=0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
